// File: rtl/pc_unit.sv
// pc_unit: fetch-address register with jump/call/return/trap handling and a
// circular return-address stack. Requests resolve by fixed priority, one per
// cycle: trap, stall, ret, call, jmp, incr, hold.
module pc_unit #(
    parameter int unsigned     bits      = 32,
    parameter int unsigned     isize     = 2,
    parameter int unsigned     depth     = 4,
    parameter logic [bits-1:0] resetaddr = '0,
    parameter logic [bits-1:0] trapaddr  = bits'('h100)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            incr,
    input  logic            jmp,
    input  logic            call,
    input  logic            ret,
    input  logic            trap,
    input  logic [bits-1:0] jaddr,
    output logic [bits-1:0] addr,
    output logic [bits-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_ovf,
    output logic            ras_unf
);

    localparam int unsigned     PW    = $clog2(depth);
    localparam logic [bits-1:0] STEP  = bits'(1) << isize;
    localparam logic [PW:0]     FULLC = (PW + 1)'(depth);

    logic [bits-1:0] addr_q, addr_d;
    logic [bits-1:0] epc_q,  epc_d;
    logic [PW-1:0]   top_q,  top_d;
    logic [PW:0]     cnt_q,  cnt_d;
    logic            ovf_q,  ovf_d;
    logic            unf_q,  unf_d;
    logic            push;
    logic [bits-1:0] link;
    logic [bits-1:0] ras_q [depth];

    assign link = addr_q + STEP;

    // Next-state selection by request priority; trap overrides stall.
    always_comb begin
        addr_d = addr_q;
        epc_d  = epc_q;
        top_d  = top_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push   = 1'b0;
        if (trap) begin
            epc_d  = addr_q;
            addr_d = trapaddr;
        end else if (!stall) begin
            if (ret) begin
                if (cnt_q != '0) begin
                    addr_d = ras_q[top_q];
                    top_d  = top_q - PW'(1);
                    cnt_d  = cnt_q - (PW + 1)'(1);
                end else begin
                    // Empty stack: fall back to the supplied target.
                    addr_d = jaddr;
                    unf_d  = 1'b1;
                end
            end else if (call) begin
                // Pointer wraps modulo depth, so a full stack overwrites its oldest entry.
                push   = 1'b1;
                top_d  = top_q + PW'(1);
                addr_d = jaddr;
                if (cnt_q == FULLC) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + (PW + 1)'(1);
                end
            end else if (jmp) begin
                addr_d = jaddr;
            end else if (incr) begin
                addr_d = link;
            end
        end
    end

    // Control and address registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q <= resetaddr;
            epc_q  <= '0;
            top_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            epc_q  <= epc_d;
            top_q  <= top_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_q[top_d] <= link;
        end
    end

    assign addr      = addr_q;
    assign epc       = epc_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULLC);
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus randomized traffic, checked
// by a queue-based reference model through a scoreboard.
module tb_pc_unit;

    localparam logic [31:0] RESETADDR = 32'h0;
    localparam logic [31:0] TRAPADDR  = 32'h100;
    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] STEP      = 32'd4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall, incr, jmp, call, ret, trap;
    logic [31:0] jaddr;
    logic [31:0] addr, epc;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;

    pc_unit #(
        .bits      (32),
        .isize     (2),
        .depth     (DEPTH),
        .resetaddr (RESETADDR),
        .trapaddr  (TRAPADDR)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .stall     (stall),
        .incr      (incr),
        .jmp       (jmp),
        .call      (call),
        .ret       (ret),
        .trap      (trap),
        .jaddr     (jaddr),
        .addr      (addr),
        .epc       (epc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the return stack is a plain queue whose oldest entry
    // is discarded when it grows past DEPTH.
    logic [31:0] m_addr, m_epc;
    logic [31:0] m_ras[$];
    logic        m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = RESETADDR;
        m_epc  = '0;
        m_ras.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_addr",  addr,             RESETADDR);
        chk("rst_epc",   epc,              32'h0);
        chk("rst_empty", 32'(ras_empty),   32'h1);
        chk("rst_full",  32'(ras_full),    32'h0);
        chk("rst_ovf",   32'(ras_ovf),     32'h0);
        chk("rst_unf",   32'(ras_unf),     32'h0);
    endtask

    // Drive one request at the falling edge, advance the model, queue the
    // expectation, and return at the rising edge that samples it.
    task automatic step(input logic st, input logic inc, input logic j, input logic c,
                        input logic r, input logic t, input logic [31:0] ja);
        exp_t e;
        @(negedge clk);
        stall = st; incr = inc; jmp = j; call = c; ret = r; trap = t; jaddr = ja;
        if (t) begin
            m_epc  = m_addr;
            m_addr = TRAPADDR;
        end else if (!st) begin
            if (r) begin
                if (m_ras.size() > 0) begin
                    m_addr = m_ras.pop_back();
                end else begin
                    m_addr = ja;
                    m_unf  = 1'b1;
                end
            end else if (c) begin
                m_ras.push_back(m_addr + STEP);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_addr = ja;
            end else if (j) begin
                m_addr = ja;
            end else if (inc) begin
                m_addr = m_addr + STEP;
            end
        end
        e.addr  = m_addr;
        e.epc   = m_epc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sbq.push_back(e);
        @(posedge clk);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear before any edge.
    task automatic async_reset();
        #3 rstn = 1'b0;
        #1 chk_reset_outputs();
        model_reset();
        #1 rstn = 1'b1;
    endtask

    // Monitor: one expectation per sampled edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_addr",  addr,           e.addr);
                chk("sb_epc",   epc,            e.epc);
                chk("sb_empty", 32'(ras_empty), 32'(e.empty));
                chk("sb_full",  32'(ras_full),  32'(e.full));
                chk("sb_ovf",   32'(ras_ovf),   32'(e.ovf));
                chk("sb_unf",   32'(ras_unf),   32'(e.unf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        {stall, incr, jmp, call, ret, trap} = '0;
        jaddr = '0;
        model_reset();
        #1 chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Reset and increment
        step(0, 1, 0, 0, 0, 0, 32'h0); #2 chk("incr1", addr, 32'h4);
        step(0, 1, 0, 0, 0, 0, 32'h0); #2 chk("incr2", addr, 32'h8);
        step(0, 1, 0, 0, 0, 0, 32'h0); #2 chk("incr3", addr, 32'hC);
        chk("incr_empty", 32'(ras_empty), 32'h1);
        chk("incr_epc", epc, 32'h0);

        // Wrap-around
        step(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC); #2 chk("wrap_jmp", addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0, 32'h0);         #2 chk("wrap_incr", addr, 32'h0);

        // Nested call/return
        step(0, 0, 1, 0, 0, 0, 32'h10);
        step(0, 0, 0, 1, 0, 0, 32'h40); #2 chk("call1", addr, 32'h40);
        step(0, 1, 0, 0, 0, 0, 32'h0);  #2 chk("call_incr", addr, 32'h44);
        step(0, 0, 0, 1, 0, 0, 32'h80); #2 chk("call2", addr, 32'h80);
        step(0, 0, 0, 0, 1, 0, 32'h0);  #2 chk("ret1", addr, 32'h48);
        step(0, 0, 0, 0, 1, 0, 32'h0);  #2 chk("ret2", addr, 32'h14);
        chk("nest_empty", 32'(ras_empty), 32'h1);
        chk("nest_ovf", 32'(ras_ovf), 32'h0);
        chk("nest_unf", 32'(ras_unf), 32'h0);

        // Overflow and underflow
        step(0, 0, 1, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, 0, 0, 32'(i) * 32'h100);
        #2 chk("ovf_full", 32'(ras_full), 32'h1);
        chk("ovf_flag", 32'(ras_ovf), 32'h1);
        step(0, 0, 0, 0, 1, 0, 32'h0); #2 chk("oret1", addr, 32'h404);
        step(0, 0, 0, 0, 1, 0, 32'h0); #2 chk("oret2", addr, 32'h304);
        step(0, 0, 0, 0, 1, 0, 32'h0); #2 chk("oret3", addr, 32'h204);
        step(0, 0, 0, 0, 1, 0, 32'h0); #2 chk("oret4", addr, 32'h104);
        step(0, 0, 0, 0, 1, 0, 32'h900); #2 chk("uret_addr", addr, 32'h900);
        chk("uret_unf", 32'(ras_unf), 32'h1);

        // Trap priority over stall/jmp/call, then stall holds
        step(0, 0, 0, 1, 0, 0, 32'h20);
        step(1, 0, 1, 1, 0, 1, 32'h55C); #2 chk("trap_addr", addr, TRAPADDR);
        chk("trap_epc", epc, 32'h20);
        chk("trap_cnt", 32'(ras_empty), 32'h0);
        step(1, 0, 0, 0, 0, 0, 32'h0); #2 chk("stall_addr", addr, TRAPADDR);
        chk("stall_epc", epc, 32'h20);

        // Asynchronous reset mid-operation
        step(0, 0, 0, 1, 0, 0, 32'h200);
        step(0, 0, 0, 1, 0, 0, 32'h300);
        async_reset();
        step(0, 0, 0, 0, 1, 0, 32'h30); #2 chk("post_rst_ret", addr, 32'h30);
        chk("post_rst_unf", 32'(ras_unf), 32'h1);

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ja;
            ja = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, ja);
            if ($urandom_range(0, 99) < 2) async_reset();
        end

        step(0, 0, 0, 0, 0, 0, 32'h0);
        #2 chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
